layer_compositor: RTL and testbench

- Parametrised, pipelined successor to the fixed-order objects mux in the VGA path.
- Selects one RGB pixel from NUM_LAYERS drawing-request/RGB pairs by fixed index priority. Layer 0 has the highest priority; the background input is used when no layer draws.
- Adds four features: a transparency colour key, per-layer enables and blink that change only at frame boundaries, a valid-qualified two-stage pipeline, and per-frame collision reporting between layer 0 (claw) and every other layer.
- Sits between the object drawers and the VGA controller.

---
 rtl/layer_compositor.sv | 177 +++++++++++++++++
 tb/tb_layer_compositor.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_compositor.sv
// Priority compositor for the VGA path: picks one pixel from NUM_LAYERS layers over a background,
// with colour-key transparency, frame-synchronous enable/blink, a two-stage pipeline and claw collision flags.
module layer_compositor #(
  parameter int                 NUM_LAYERS   = 8,
  parameter int                 RGB_W        = 8,
  parameter logic [RGB_W-1:0]   TRANSPARENT  = 8'hFF,
  parameter int                 BLINK_FRAMES = 16,
  parameter int                 IDX_W        = $clog2(NUM_LAYERS + 1)
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        sof,
  input  logic                        pixel_valid_in,
  input  logic [NUM_LAYERS-1:0]       layer_dr,
  input  logic [NUM_LAYERS*RGB_W-1:0] layer_rgb,
  input  logic [RGB_W-1:0]            bg_rgb,
  input  logic [NUM_LAYERS-1:0]       layer_en,
  input  logic [NUM_LAYERS-1:0]       blink_en,
  output logic [RGB_W-1:0]            RGBOut,
  output logic                        pixel_valid_out,
  output logic [IDX_W-1:0]            winner_idx,
  output logic [NUM_LAYERS-1:0]       collision_vec,
  output logic                        collision_irq
);

  localparam int               CNT_W    = $clog2(BLINK_FRAMES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [IDX_W-1:0] IDX_BG   = IDX_W'(NUM_LAYERS);

  // frame-synchronous control state
  logic [NUM_LAYERS-1:0]       en_act_q,      en_act_d;
  logic [NUM_LAYERS-1:0]       blink_act_q,   blink_act_d;
  logic                        blink_phase_q, blink_phase_d;
  logic [CNT_W-1:0]            frame_cnt_q,   frame_cnt_d;
  logic [NUM_LAYERS-1:0]       acc_q,         acc_d;
  logic [NUM_LAYERS-1:0]       coll_vec_q,    coll_vec_d;
  logic                        coll_irq_q,    coll_irq_d;

  // stage 1 registers
  logic [NUM_LAYERS-1:0]       s1_dr_q,       s1_dr_d;
  logic [NUM_LAYERS*RGB_W-1:0] s1_rgb_q,      s1_rgb_d;
  logic [RGB_W-1:0]            s1_bg_q,       s1_bg_d;
  logic                        s1_valid_q,    s1_valid_d;

  // stage 2 (output) registers
  logic [RGB_W-1:0]            rgb_out_q,     rgb_out_d;
  logic [IDX_W-1:0]            winner_q,      winner_d;
  logic                        valid_out_q,   valid_out_d;

  logic [NUM_LAYERS-1:0]       eff_dr_s;
  logic [NUM_LAYERS-1:0]       hits_s;

  // Effective draw request: drawing, not colour-keyed, enabled, not blinked off, active video.
  always_comb begin
    eff_dr_s = {NUM_LAYERS{1'b0}};
    for (int k = 0; k < NUM_LAYERS; k++) begin
      eff_dr_s[k] = layer_dr[k]
                  & (layer_rgb[k*RGB_W +: RGB_W] != TRANSPARENT)
                  & en_act_q[k]
                  & ~(blink_act_q[k] & blink_phase_q)
                  & pixel_valid_in;
    end
  end

  // Claw (layer 0) overlap with each other layer on this pixel.
  always_comb begin
    hits_s = {NUM_LAYERS{1'b0}};
    if (eff_dr_s[0]) begin
      hits_s = {eff_dr_s[NUM_LAYERS-1:1], 1'b0};
    end else begin
      hits_s = {NUM_LAYERS{1'b0}};
    end
  end

  // Frame-boundary updates: enables, blink timing and collision hand-off.
  always_comb begin
    en_act_d      = en_act_q;
    blink_act_d   = blink_act_q;
    blink_phase_d = blink_phase_q;
    frame_cnt_d   = frame_cnt_q;
    acc_d         = acc_q | hits_s;
    coll_vec_d    = coll_vec_q;
    coll_irq_d    = 1'b0;
    if (sof) begin
      en_act_d    = layer_en;
      blink_act_d = blink_en;
      coll_vec_d  = acc_q;
      coll_irq_d  = (acc_q != {NUM_LAYERS{1'b0}});
      // hits in the sof cycle already belong to the new frame
      acc_d       = hits_s;
      if (frame_cnt_q == CNT_LAST) begin
        frame_cnt_d   = {CNT_W{1'b0}};
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d   = frame_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      coll_irq_d = 1'b0;
    end
  end

  // Stage 1 capture.
  always_comb begin
    s1_dr_d    = eff_dr_s;
    s1_rgb_d   = layer_rgb;
    s1_bg_d    = bg_rgb;
    s1_valid_d = pixel_valid_in;
  end

  // Stage 2: lowest set index wins; background otherwise; blank outside active video.
  always_comb begin
    rgb_out_d   = {RGB_W{1'b0}};
    winner_d    = IDX_BG;
    valid_out_d = s1_valid_q;
    if (s1_valid_q) begin
      rgb_out_d = s1_bg_q;
      for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
        if (s1_dr_q[k]) begin
          rgb_out_d = s1_rgb_q[k*RGB_W +: RGB_W];
          winner_d  = IDX_W'(k);
        end
      end
    end else begin
      rgb_out_d = {RGB_W{1'b0}};
      winner_d  = IDX_BG;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      en_act_q      <= {NUM_LAYERS{1'b1}};
      blink_act_q   <= {NUM_LAYERS{1'b0}};
      blink_phase_q <= 1'b0;
      frame_cnt_q   <= {CNT_W{1'b0}};
      acc_q         <= {NUM_LAYERS{1'b0}};
      coll_vec_q    <= {NUM_LAYERS{1'b0}};
      coll_irq_q    <= 1'b0;
    end else begin
      en_act_q      <= en_act_d;
      blink_act_q   <= blink_act_d;
      blink_phase_q <= blink_phase_d;
      frame_cnt_q   <= frame_cnt_d;
      acc_q         <= acc_d;
      coll_vec_q    <= coll_vec_d;
      coll_irq_q    <= coll_irq_d;
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      s1_dr_q     <= {NUM_LAYERS{1'b0}};
      s1_rgb_q    <= {(NUM_LAYERS*RGB_W){1'b0}};
      s1_bg_q     <= {RGB_W{1'b0}};
      s1_valid_q  <= 1'b0;
      rgb_out_q   <= {RGB_W{1'b0}};
      winner_q    <= {IDX_W{1'b0}};
      valid_out_q <= 1'b0;
    end else begin
      s1_dr_q     <= s1_dr_d;
      s1_rgb_q    <= s1_rgb_d;
      s1_bg_q     <= s1_bg_d;
      s1_valid_q  <= s1_valid_d;
      rgb_out_q   <= rgb_out_d;
      winner_q    <= winner_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign RGBOut          = rgb_out_q;
  assign winner_idx      = winner_q;
  assign pixel_valid_out = valid_out_q;
  assign collision_vec   = coll_vec_q;
  assign collision_irq   = coll_irq_q;

endmodule

// File: tb/tb_layer_compositor.sv
// Bench for layer_compositor: directed literal checks from the test plan plus randomized traffic
// compared every cycle against a frame-level reference model.
module tb_layer_compositor;

  localparam int NL = 8;
  localparam int BF = 2;

  logic          clk = 1'b0;
  logic          resetN = 1'b1;
  logic          sof = 1'b0;
  logic          pixel_valid_in = 1'b0;
  logic [NL-1:0] layer_dr = '0;
  logic [NL*8-1:0] layer_rgb = '0;
  logic [7:0]    bg_rgb = '0;
  logic [NL-1:0] layer_en = '1;
  logic [NL-1:0] blink_en = '0;
  logic [7:0]    RGBOut;
  logic          pixel_valid_out;
  logic [3:0]    winner_idx;
  logic [NL-1:0] collision_vec;
  logic          collision_irq;

  int n_checks = 0;
  int n_errors = 0;

  layer_compositor #(.NUM_LAYERS(NL), .RGB_W(8), .TRANSPARENT(8'hFF), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .resetN(resetN), .sof(sof), .pixel_valid_in(pixel_valid_in),
    .layer_dr(layer_dr), .layer_rgb(layer_rgb), .bg_rgb(bg_rgb),
    .layer_en(layer_en), .blink_en(blink_en),
    .RGBOut(RGBOut), .pixel_valid_out(pixel_valid_out), .winner_idx(winner_idx),
    .collision_vec(collision_vec), .collision_irq(collision_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [NL-1:0] m_en, m_blink, m_acc, m_cvec;
  logic          m_phase, m_irq;
  int            m_cnt;
  logic [7:0]    m_rgb, e_rgb;
  int            m_idx, e_idx;
  logic          m_v, e_v;

  function automatic logic [NL-1:0] vis_mask();
    logic [NL-1:0] m;
    m = '0;
    for (int k = 0; k < NL; k++)
      m[k] = pixel_valid_in && layer_dr[k] && (layer_rgb[k*8 +: 8] != 8'hFF)
             && m_en[k] && !(m_blink[k] && m_phase);
    return m;
  endfunction

  function automatic int winner_of(input logic [NL-1:0] m);
    int w;
    w = NL;
    for (int k = 0; k < NL; k++)
      if (m[k] && w == NL) w = k;
    return w;
  endfunction

  function automatic logic [7:0] colour_of(input int w);
    if (w == NL) return pixel_valid_in ? bg_rgb : 8'h00;
    return layer_rgb[w*8 +: 8];
  endfunction

  function automatic logic [NL-1:0] hit_mask(input logic [NL-1:0] m);
    return m[0] ? (m & ~NL'(1)) : '0;
  endfunction

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      m_en <= '1; m_blink <= '0; m_phase <= 1'b0; m_cnt <= 0;
      m_acc <= '0; m_cvec <= '0; m_irq <= 1'b0;
      m_rgb <= 8'h00; m_idx <= NL; m_v <= 1'b0;
      e_rgb <= 8'h00; e_idx <= 0; e_v <= 1'b0;
    end else begin
      e_rgb <= m_rgb; e_idx <= m_idx; e_v <= m_v;
      m_v   <= pixel_valid_in;
      m_idx <= winner_of(vis_mask());
      m_rgb <= colour_of(winner_of(vis_mask()));
      if (sof) begin
        m_en    <= layer_en;
        m_blink <= blink_en;
        m_cvec  <= m_acc;
        m_irq   <= (m_acc != '0);
        m_acc   <= hit_mask(vis_mask());
        m_cnt   <= (m_cnt == BF - 1) ? 0 : m_cnt + 1;
        if (m_cnt == BF - 1) m_phase <= ~m_phase;
      end else begin
        m_acc <= m_acc | hit_mask(vis_mask());
        m_irq <= 1'b0;
      end
    end
  end

  // Compare process: every output against the model on every falling edge.
  always @(negedge clk) begin
    check("model_rgb",   32'(RGBOut),          32'(e_rgb));
    check("model_idx",   32'(winner_idx),      32'(e_idx));
    check("model_valid", 32'(pixel_valid_out), 32'(e_v));
    check("model_cvec",  32'(collision_vec),   32'(m_cvec));
    check("model_irq",   32'(collision_irq),   32'(m_irq));
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_rgb(input int k, input logic [7:0] c);
    layer_rgb[k*8 +: 8] = c;
  endtask

  logic vis_exp;

  initial begin
    #1 resetN = 1'b0;
    step(2);
    check("reset_rgb",   32'(RGBOut), 32'h0);
    check("reset_idx",   32'(winner_idx), 32'h0);
    check("reset_valid", 32'(pixel_valid_out), 32'h0);
    check("reset_cvec",  32'(collision_vec), 32'h0);
    resetN = 1'b1;
    step(1);

    // priority
    pixel_valid_in = 1'b1; layer_dr = 8'b0000_0110;
    set_rgb(1, 8'h1C); set_rgb(2, 8'hE0); bg_rgb = 8'h49;
    step(2);
    check("prio_rgb", 32'(RGBOut), 32'h1C);
    check("prio_idx", 32'(winner_idx), 32'd1);

    // transparency
    layer_dr = 8'b0000_0011; set_rgb(0, 8'hFF); set_rgb(1, 8'h03);
    step(2);
    check("transp_rgb", 32'(RGBOut), 32'h03);
    check("transp_idx", 32'(winner_idx), 32'd1);
    layer_dr = 8'h00;
    step(2);
    check("bg_rgb", 32'(RGBOut), 32'h49);
    check("bg_idx", 32'(winner_idx), 32'd8);

    // enable timing
    sof = 1'b1; layer_dr = 8'b0000_0010; set_rgb(1, 8'h55);
    step(1); sof = 1'b0; layer_en = 8'b1111_1101;
    step(2);
    check("en_mid1_idx", 32'(winner_idx), 32'd1);
    step(2);
    check("en_mid2_idx", 32'(winner_idx), 32'd1);
    sof = 1'b1;
    step(1); sof = 1'b0;
    step(1);
    check("en_sofpix_idx", 32'(winner_idx), 32'd1);
    step(1);
    check("en_off_idx", 32'(winner_idx), 32'd8);
    check("en_off_rgb", 32'(RGBOut), 32'h49);
    layer_en = 8'hFF;

    // collision between layer 0 and layer 3
    layer_dr = 8'h00; sof = 1'b1;
    step(1); sof = 1'b0;
    step(1);
    layer_dr = 8'b0000_1001; set_rgb(0, 8'h12); set_rgb(3, 8'h34);
    step(1); layer_dr = 8'h00;
    step(3); sof = 1'b1;
    step(1);
    check("coll_vec", 32'(collision_vec), 32'h08);
    check("coll_irq", 32'(collision_irq), 32'h1);
    sof = 1'b0;
    step(1);
    check("coll_irq_once", 32'(collision_irq), 32'h0);
    check("coll_vec_hold", 32'(collision_vec), 32'h08);
    step(3); sof = 1'b1;
    step(1);
    check("coll_clear_vec", 32'(collision_vec), 32'h0);
    check("coll_clear_irq", 32'(collision_irq), 32'h0);
    step(1);
    check("b2b_vec", 32'(collision_vec), 32'h0);
    sof = 1'b0;

    // collision 0/2, then reset mid-line
    layer_dr = 8'b0000_0101; set_rgb(2, 8'hE0);
    step(1); layer_dr = 8'h00; sof = 1'b1;
    step(1); sof = 1'b0;
    check("coll2_vec", 32'(collision_vec), 32'h04);
    layer_dr = 8'b0000_0010; set_rgb(1, 8'h55);
    step(3);
    #2 resetN = 1'b0;
    #1;
    check("rst_mid_rgb",   32'(RGBOut), 32'h0);
    check("rst_mid_valid", 32'(pixel_valid_out), 32'h0);
    check("rst_mid_cvec",  32'(collision_vec), 32'h0);
    step(1); resetN = 1'b1;
    step(1);
    check("rel_valid0", 32'(pixel_valid_out), 32'h0);
    step(1);
    check("rel_valid1", 32'(pixel_valid_out), 32'h1);
    check("rel_rgb",    32'(RGBOut), 32'h55);

    // blink: first sampled frame visible, then hidden 2, visible 2, ...
    blink_en = 8'b0000_0100; layer_dr = 8'b0000_0100; set_rgb(2, 8'hAA); bg_rgb = 8'h11;
    for (int f = 0; f < 6; f++) begin
      sof = 1'b1;
      step(1); sof = 1'b0;
      step(2);
      vis_exp = (f == 0) || (f == 3) || (f == 4);
      check("blink_rgb", 32'(RGBOut), vis_exp ? 32'hAA : 32'h11);
      step(3);
    end
    blink_en = 8'h00;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      sof = ($urandom_range(0, 15) == 0) || (sof && $urandom_range(0, 3) == 0);
      pixel_valid_in = ($urandom_range(0, 9) != 0);
      layer_dr = 8'($urandom);
      if ($urandom_range(0, 1) == 0) layer_dr[0] = 1'b1;
      for (int k = 0; k < NL; k++)
        set_rgb(k, ($urandom_range(0, 4) == 0) ? 8'hFF : 8'($urandom));
      bg_rgb = 8'($urandom);
      layer_en = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      blink_en = 8'($urandom);
      if (i == 1500) begin
        #2 resetN = 1'b0;
        step(1); resetN = 1'b1;
      end else begin
        step(1);
      end
    end

    sof = 1'b0; pixel_valid_in = 1'b0;
    step(3);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
